// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant, grant index and valid.
// The priority pointer names the highest-priority port; after a new grant it
// moves one past the winner, so every requester is reached in turn.
// Optional lock mode (define RR_ARB_LOCK_EN): the current holder keeps the
// grant for up to MAX_HOLD consecutive cycles while it keeps requesting.
// Without the macro the holder limit is forced to 1, so every cycle
// re-arbitrates. This is also why MAX_HOLD=1 in lock mode is indistinguishable
// from lock disabled.
module rr_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int MAX_HOLD  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_PORTS-1:0]         req_i,
    output logic [NUM_PORTS-1:0]         gnt_o,
    output logic [$clog2(NUM_PORTS)-1:0] gnt_id_o,
    output logic                         gnt_vld_o
);

    localparam int PW = $clog2(NUM_PORTS);
    localparam int HW = $clog2(MAX_HOLD + 1);

`ifdef RR_ARB_LOCK_EN
    localparam int HOLD_LIMIT = MAX_HOLD;
`else
    localparam int HOLD_LIMIT = 1;
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_PORTS-1:0]   gnt_q, gnt_d;
    logic [PW-1:0]          gnt_id_q, gnt_id_d;
    logic                   gnt_vld_q, gnt_vld_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [HW-1:0]          hold_cnt_q, hold_cnt_d;

    logic                   arb_found;
    logic [PW-1:0]          arb_idx;
    logic [NUM_PORTS-1:0]   arb_onehot;
    logic                   keep_hold;

    // Search for the first requester starting at ptr, wrapping past the top port.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!arb_found && req_i[(int'(ptr_q) + i) % NUM_PORTS]) begin
                arb_found = 1'b1;
                arb_idx   = PW'((int'(ptr_q) + i) % NUM_PORTS);
            end
        end
    end

    // One-hot decode of the search winner.
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_onehot
        assign arb_onehot[gi] = (arb_idx == PW'(gi));
    end

    // Next-state logic: keep the current holder, grant a new winner, or go idle.
    always_comb begin
        state_d    = state_q;
        gnt_d      = '0;
        gnt_id_d   = '0;
        gnt_vld_d  = 1'b0;
        ptr_d      = ptr_q;
        hold_cnt_d = '0;
        keep_hold  = (state_q == GRANT) && req_i[gnt_id_q] &&
                     (hold_cnt_q < HW'(HOLD_LIMIT));

        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d    = GRANT;
                    gnt_d      = arb_onehot;
                    gnt_id_d   = arb_idx;
                    gnt_vld_d  = 1'b1;
                    ptr_d      = (arb_idx == PW'(NUM_PORTS - 1)) ? '0 : arb_idx + 1'b1;
                    hold_cnt_d = HW'(1);
                end
            end
            GRANT: begin
                if (keep_hold) begin
                    // Holder stays; the pointer already sits one past it.
                    state_d    = GRANT;
                    gnt_d      = gnt_q;
                    gnt_id_d   = gnt_id_q;
                    gnt_vld_d  = 1'b1;
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end else if (arb_found) begin
                    state_d    = GRANT;
                    gnt_d      = arb_onehot;
                    gnt_id_d   = arb_idx;
                    gnt_vld_d  = 1'b1;
                    ptr_d      = (arb_idx == PW'(NUM_PORTS - 1)) ? '0 : arb_idx + 1'b1;
                    hold_cnt_d = HW'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            gnt_vld_q  <= 1'b0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            gnt_vld_q  <= gnt_vld_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign gnt_id_o  = gnt_id_q;
    assign gnt_vld_o = gnt_vld_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed-vector bench for rr_arbiter (NUM_PORTS=4, MAX_HOLD=4).
// Stimulus pushes hand-computed expectations into a queue; a monitor pops one
// entry per clock, just after the edge the vector was sampled on.
// Lock-mode vectors are selected with RR_ARB_LOCK_EN, matching the RTL build.
module tb_rr_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req_i;
    logic [3:0] gnt_o;
    logic [1:0] gnt_id_o;
    logic       gnt_vld_o;

    typedef struct {
        logic [3:0] gnt;
        int         hold;   // -1: not checked
        int         ptr;    // -1: not checked
        string      name;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    rr_arbiter #(.NUM_PORTS(4), .MAX_HOLD(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req_i),
        .gnt_o     (gnt_o),
        .gnt_id_o  (gnt_id_o),
        .gnt_vld_o (gnt_vld_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int onehot_idx(input logic [3:0] v);
        int r = 0;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic step(input logic rst, input logic [3:0] req, input logic [3:0] eg,
                        input int eh, input int ep, input string nm);
        exp_t e;
        @(negedge clk);
        reset = rst;
        req_i = req;
        e.gnt = eg; e.hold = eh; e.ptr = ep; e.name = nm;
        q.push_back(e);
    endtask

    // Monitor: compare registered outputs right after each sampling edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                if (gnt_o !== e.gnt) begin
                    n_miss++;
                    $display("FAIL %s gnt_o: got %b expected %b", e.name, gnt_o, e.gnt);
                end
                n_vec++;
                if (int'(gnt_id_o) != onehot_idx(e.gnt) || $isunknown(gnt_id_o)) begin
                    n_miss++;
                    $display("FAIL %s gnt_id_o: got %0d expected %0d", e.name, gnt_id_o, onehot_idx(e.gnt));
                end
                n_vec++;
                if (gnt_vld_o !== (|e.gnt)) begin
                    n_miss++;
                    $display("FAIL %s gnt_vld_o: got %b expected %b", e.name, gnt_vld_o, |e.gnt);
                end
                if (e.hold >= 0) begin
                    n_vec++;
                    if (int'(dut.hold_cnt_q) != e.hold) begin
                        n_miss++;
                        $display("FAIL %s hold_cnt: got %0d expected %0d", e.name, dut.hold_cnt_q, e.hold);
                    end
                end
                if (e.ptr >= 0) begin
                    n_vec++;
                    if (int'(dut.ptr_q) != e.ptr) begin
                        n_miss++;
                        $display("FAIL %s ptr: got %0d expected %0d", e.name, dut.ptr_q, e.ptr);
                    end
                end
                $display("vec %-10s req=%b gnt=%b id=%0d vld=%b", e.name, req_i, gnt_o, gnt_id_o, gnt_vld_o);
            end
        end
    end

    initial begin : driver
        logic [3:0] tmp;
        reset = 1'b1;
        req_i = 4'b0000;

        // Requests held through reset are ignored; first grant starts at port 0.
        step(1'b1, 4'b1111, 4'b0000, 0, 0, "reset0");
        step(1'b1, 4'b1111, 4'b0000, 0, 0, "reset1");
        step(1'b0, 4'b1111, 4'b0001, 1, 1, "first");

`ifdef RR_ARB_LOCK_EN
        // Each port holds MAX_HOLD cycles under constant full request.
        for (int k = 1; k < 16; k++) begin
            tmp = 4'b0001 << (k / 4);
            step(1'b0, 4'b1111, tmp, (k % 4) + 1, ((k / 4) + 1) % 4, "lock_rot");
        end
        step(1'b0, 4'b1111, 4'b0001, 1, 1, "lock_wrap");
        // Early release: port 1 holds 2 cycles, then drops.
        step(1'b0, 4'b0010, 4'b0010, 1, 2, "rel_a");
        step(1'b0, 4'b1011, 4'b0010, 2, 2, "rel_b");
        step(1'b0, 4'b1001, 4'b1000, 1, 0, "rel_c");
        // Reset in the middle of a hold on port 2.
        step(1'b0, 4'b0100, 4'b0100, 1, 3, "mid_a");
        step(1'b0, 4'b0100, 4'b0100, 2, 3, "mid_b");
        step(1'b1, 4'b0100, 4'b0000, 0, 0, "mid_rst");
        step(1'b0, 4'b0100, 4'b0100, 1, 3, "mid_post");
        step(1'b0, 4'b0000, 4'b0000, 0, 3, "idle");
`else
        // Plain rotation under constant full request.
        step(1'b0, 4'b1111, 4'b0010, 1, 2, "rot1");
        step(1'b0, 4'b1111, 4'b0100, 1, 3, "rot2");
        step(1'b0, 4'b1111, 4'b1000, 1, 0, "rot3");
        step(1'b0, 4'b1111, 4'b0001, 1, 1, "rot4");
        // Grant port 2 (ptr becomes 3), then wrap to the low ports.
        step(1'b0, 4'b0100, 4'b0100, 1, 3, "wrap_a");
        step(1'b0, 4'b0011, 4'b0001, 1, 1, "wrap_b");
        step(1'b0, 4'b0011, 4'b0010, 1, 2, "wrap_c");
        step(1'b0, 4'b0000, 4'b0000, 0, 2, "none");
        // Non-requesting ports are skipped.
        step(1'b0, 4'b1000, 4'b1000, 1, 0, "top");
        step(1'b0, 4'b1010, 4'b0010, 1, 2, "alt_a");
        step(1'b0, 4'b1010, 4'b1000, 1, 0, "alt_b");
        // Reset mid-stream restarts from ptr=0.
        step(1'b1, 4'b0110, 4'b0000, 0, 0, "mid_rst");
        step(1'b0, 4'b0110, 4'b0010, 1, 2, "post_a");
        step(1'b0, 4'b0110, 4'b0100, 1, 3, "post_b");
        step(1'b0, 4'b0000, 4'b0000, 0, 3, "idle");
`endif

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        n_vec++;
        if (q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Reset SHALL be synchronous and active-high on a single clock: one clock (clk), synchronous active-high reset (reset).
REQ-002 Parameter NUM_PORTS, default 4: number of requesters; SHALL be >= 2.
REQ-003 Parameter MAX_HOLD, default 4: maximum consecutive grant cycles per holder in lock mode; SHALL be >= 1.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port reset, input, 1: synchronous active-high reset.
REQ-006 Port req_i, input, NUM_PORTS: request vector; bit i = port i requesting.
REQ-007 Port gnt_o, output, NUM_PORTS: registered grant, one-hot or zero.
REQ-008 Port gnt_id_o, output, $clog2(NUM_PORTS): index of the granted port; 0 when gnt_o is zero.
REQ-009 Port gnt_vld_o, output, 1: high iff gnt_o is non-zero.

Function
REQ-010 All outputs SHALL be registered; a grant computed from req_i sampled at edge N SHALL appear after edge N (1-cycle latency).
REQ-011 Internal priority pointer ptr, width $clog2(NUM_PORTS): ptr is the highest-priority port index.
REQ-012 Arbitration: search req_i from ptr upward, wrap NUM_PORTS-1 -> 0; first set bit k wins.
REQ-013 On a new grant to port k: ptr <= (k+1) mod NUM_PORTS; port NUM_PORTS-1 wraps ptr to 0.
REQ-014 req_i == 0: gnt_o <= 0, gnt_id_o <= 0, gnt_vld_o <= 0, ptr unchanged.
REQ-015 gnt_o SHALL never have more than one bit set.
REQ-016 A grant SHALL only go to a port whose req_i bit was high at the sampling edge; non-requesting ports are never granted.
REQ-017 FSM states: IDLE (no grant) and GRANT (grant outstanding). IDLE -> GRANT on any request; GRANT -> IDLE when no grant is issued; GRANT -> GRANT on re-grant or hold.
REQ-018 Hold counter hold_cnt, width $clog2(MAX_HOLD+1): set to 1 on a new grant; cleared in IDLE.
REQ-019 Starvation bound: with all ports requesting, each port SHALL be granted within NUM_PORTS*MAX_HOLD cycles (lock mode) or NUM_PORTS cycles (no lock).
REQ-020 Requests that are dropped are not remembered; no request queueing.

Reset
REQ-021 While reset is high at a clock edge: gnt_o=0, gnt_id_o=0, gnt_vld_o=0, ptr=0, hold_cnt=0, state=IDLE; req_i is ignored.
REQ-022 The first edge after reset deasserts SHALL arbitrate normally from ptr=0.
REQ-023 Reset asserted mid-hold SHALL abort the hold; no outputs survive reset.

Configuration
REQ-024 Macro RR_ARB_LOCK_EN selects lock mode.
REQ-025 With RR_ARB_LOCK_EN: if the current holder h still requests and hold_cnt < MAX_HOLD, the grant SHALL stay on h, hold_cnt increments, and ptr is unchanged; otherwise normal arbitration per REQ-012, starting at ptr = h+1.
REQ-026 Without RR_ARB_LOCK_EN: every cycle re-arbitrates per REQ-012; hold_cnt and MAX_HOLD have no effect; a continuous requester gets at most 1 consecutive cycle when others request.
REQ-027 MAX_HOLD=1 with RR_ARB_LOCK_EN SHALL behave identically to lock disabled.

Verification (NUM_PORTS=4, MAX_HOLD=4)
REQ-028 Reset: req_i=4'b1111 held through reset -> gnt_o=0, gnt_vld_o=0 during reset; first post-reset grant is 4'b0001 with gnt_id_o=0.
REQ-029 No lock, req_i=4'b1111 constant -> gnt_o 0001,0010,0100,1000,0001 on consecutive cycles.
REQ-030 Wrap: after a grant to port 2 (ptr=3), req_i=4'b0011 -> gnt_o 0001, then 0010; req_i=4'b0000 -> gnt_vld_o=0 next cycle, ptr retained.
REQ-031 Lock, req_i=4'b1111 constant -> 0001 x4 cycles, 0010 x4, 0100 x4, 1000 x4, then 0001.
REQ-032 Lock early release: port 1 holds 2 cycles, then req_i changes from 4'b1011 to 4'b1001 -> next grant is 1000, hold_cnt=1.
REQ-033 Reset mid-hold (hold_cnt=2 on port 2) -> outputs zero; after release with req_i=4'b0100 -> gnt_o=0100 with hold_cnt=1.
